// File: rtl/rvx_bus_arbiter.sv
// Two-manager round-robin arbiter in front of the RVX system bus: one request in flight at a time.
// Optional forced completion of a stalled WAIT is enabled with `define RVX_ARB_TIMEOUT_EN.
module rvx_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] m0_rw_address,
    input  logic        m0_read_request,
    input  logic        m0_write_request,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_write_strobe,
    output logic [31:0] m0_read_data,
    output logic        m0_read_response,
    output logic        m0_write_response,
    input  logic [31:0] m1_rw_address,
    input  logic        m1_read_request,
    input  logic        m1_write_request,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_write_strobe,
    output logic [31:0] m1_read_data,
    output logic        m1_read_response,
    output logic        m1_write_response,
    output logic [31:0] bus_rw_address,
    output logic        bus_read_request,
    output logic        bus_write_request,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_write_strobe,
    input  logic [31:0] bus_read_data,
    input  logic        bus_read_response,
    input  logic        bus_write_response,
    output logic        bus_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic        rd_flag;
    logic        wr_flag;
    logic        req0;
    logic        req1;
    logic        pick1;
    logic        done;
    logic        timeout_hit;
    logic [31:0] resp_data;

    assign req0  = m0_read_request | m0_write_request;
    assign req1  = m1_read_request | m1_write_request;
    // m1 wins when alone, or on a tie when m0 was served last
    assign pick1 = req1 & (~req0 | ~last_grant);
    assign done  = (~rd_flag | bus_read_response) & (~wr_flag | bus_write_response);
    // a forced completion returns zero data
    assign resp_data = (done && rd_flag) ? bus_read_data : 32'h0;

`ifdef RVX_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeout_count;
    logic       timeout_flag;

    // a real completion in the same cycle takes priority over the timeout
    assign timeout_hit = ~done & (timeout_count == TIMEOUT_LAST);
    assign bus_timeout = timeout_flag;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timeout_count <= 8'd0;
            timeout_flag  <= 1'b0;
        end else begin
            timeout_flag <= (state == WAIT) && timeout_hit;
            if (state == ISSUE)
                timeout_count <= 8'd0;
            else if (state == WAIT && !done)
                timeout_count <= timeout_count + 8'd1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= IDLE;
            owner             <= 1'b0;
            last_grant        <= 1'b1;
            rd_flag           <= 1'b0;
            wr_flag           <= 1'b0;
            bus_rw_address    <= 32'h0;
            bus_read_request  <= 1'b0;
            bus_write_request <= 1'b0;
            bus_write_data    <= 32'h0;
            bus_write_strobe  <= 4'h0;
            m0_read_data      <= 32'h0;
            m0_read_response  <= 1'b0;
            m0_write_response <= 1'b0;
            m1_read_data      <= 32'h0;
            m1_read_response  <= 1'b0;
            m1_write_response <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner             <= pick1;
                        last_grant        <= pick1;
                        rd_flag           <= pick1 ? m1_read_request  : m0_read_request;
                        wr_flag           <= pick1 ? m1_write_request : m0_write_request;
                        bus_read_request  <= pick1 ? m1_read_request  : m0_read_request;
                        bus_write_request <= pick1 ? m1_write_request : m0_write_request;
                        bus_rw_address    <= pick1 ? m1_rw_address    : m0_rw_address;
                        bus_write_data    <= pick1 ? m1_write_data    : m0_write_data;
                        bus_write_strobe  <= pick1 ? m1_write_strobe  : m0_write_strobe;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_read_request  <= 1'b0;
                    bus_write_request <= 1'b0;
                    state             <= WAIT;
                end
                WAIT: begin
                    if (done || timeout_hit) begin
                        if (owner) begin
                            m1_read_response  <= rd_flag;
                            m1_write_response <= wr_flag;
                            m1_read_data      <= resp_data;
                        end else begin
                            m0_read_response  <= rd_flag;
                            m0_write_response <= wr_flag;
                            m0_read_data      <= resp_data;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    m0_read_data      <= 32'h0;
                    m0_read_response  <= 1'b0;
                    m0_write_response <= 1'b0;
                    m1_read_data      <= 32'h0;
                    m1_read_response  <= 1'b0;
                    m1_write_response <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Bench for rvx_bus_arbiter: table of single-manager transactions plus hand sequences for
// round-robin, reset mid-transaction and timeout; responses are checked against a scoreboard queue.
module tb_rvx_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] m0_rw_address, m1_rw_address, m0_write_data, m1_write_data;
    logic        m0_read_request, m0_write_request, m1_read_request, m1_write_request;
    logic [3:0]  m0_write_strobe, m1_write_strobe;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_response, m0_write_response, m1_read_response, m1_write_response;
    logic [31:0] bus_rw_address, bus_write_data, bus_read_data;
    logic        bus_read_request, bus_write_request, bus_read_response, bus_write_response;
    logic [3:0]  bus_write_strobe;
    logic        bus_timeout;

    always #5 clock = ~clock;

    rvx_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_rw_address(m0_rw_address), .m0_read_request(m0_read_request),
        .m0_write_request(m0_write_request), .m0_write_data(m0_write_data),
        .m0_write_strobe(m0_write_strobe), .m0_read_data(m0_read_data),
        .m0_read_response(m0_read_response), .m0_write_response(m0_write_response),
        .m1_rw_address(m1_rw_address), .m1_read_request(m1_read_request),
        .m1_write_request(m1_write_request), .m1_write_data(m1_write_data),
        .m1_write_strobe(m1_write_strobe), .m1_read_data(m1_read_data),
        .m1_read_response(m1_read_response), .m1_write_response(m1_write_response),
        .bus_rw_address(bus_rw_address), .bus_read_request(bus_read_request),
        .bus_write_request(bus_write_request), .bus_write_data(bus_write_data),
        .bus_write_strobe(bus_write_strobe), .bus_read_data(bus_read_data),
        .bus_read_response(bus_read_response), .bus_write_response(bus_write_response),
        .bus_timeout(bus_timeout)
    );

    typedef struct {
        bit          mgr;
        bit          rd;
        bit          wr;
        logic [31:0] data;
        bit          to;
        int          start;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          rd;
        bit          wr;
    } bus_t;

    typedef struct {
        bit          m;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        int          rw;
        int          ww;
        int          lat;
    } vec_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    vec_t  vecs[7];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    rd_wait = 0;
    int    wr_wait = 0;
    int    rd_cnt = 0;
    int    wr_cnt = 0;
    bit    dev_en = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] dev_data(input logic [31:0] addr);
        return addr ^ 32'hCAFE_1001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic drive(input bit m, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st);
        if (!m) begin
            m0_read_request = rd; m0_write_request = wr; m0_rw_address = addr;
            m0_write_data = wd; m0_write_strobe = st;
        end else begin
            m1_read_request = rd; m1_write_request = wr; m1_rw_address = addr;
            m1_write_data = wd; m1_write_strobe = st;
        end
    endtask

    task automatic expect_txn(input bit m, input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] st, input int lat, input bit to);
        resp_t r;
        bus_t  b;
        r = '{mgr: m, rd: rd, wr: wr, data: (rd && !to) ? dev_data(addr) : 32'h0,
              to: to, start: cyc, lat: lat};
        b = '{addr: addr, wdata: wd, strb: st, rd: rd, wr: wr};
        resp_q.push_back(r);
        bus_q.push_back(b);
    endtask

    task automatic issue(input bit m, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, input int lat, input bit to);
        drive(m, rd, wr, addr, wd, st);
        expect_txn(m, rd, wr, addr, wd, st, lat, to);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && resp_q.size() != 0; i++) @(negedge clock);
        if (resp_q.size() != 0) begin
            fail_now("response_never_arrived");
            resp_q.delete();
            bus_q.delete();
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic handle_resp(input bit m);
        resp_t e;
        if (resp_q.size() == 0) begin
            fail_now(m ? "unexpected_m1_response" : "unexpected_m0_response");
            return;
        end
        e = resp_q.pop_front();
        check("owner", 32'(m), 32'(e.mgr));
        check("read_response", 32'(m ? m1_read_response : m0_read_response), 32'(e.rd));
        check("write_response", 32'(m ? m1_write_response : m0_write_response), 32'(e.wr));
        if (e.rd) check("read_data", m ? m1_read_data : m0_read_data, e.data);
        if (e.lat >= 0) check("latency", 32'(cyc - e.start), 32'(e.lat));
        check("bus_timeout", 32'(bus_timeout), 32'(e.to));
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Bus device: each response rises after its programmed wait and is held until the manager sees it.
    initial begin
        bus_read_response = 1'b0; bus_write_response = 1'b0; bus_read_data = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n || m0_read_response || m0_write_response || m1_read_response ||
                m1_write_response || bus_timeout) begin
                bus_read_response = 1'b0; bus_write_response = 1'b0; bus_read_data = 32'h0;
                rd_cnt = 0; wr_cnt = 0;
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    bus_read_response = 1'b1;
                    bus_read_data = dev_data(bus_rw_address);
                end
            end
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) bus_write_response = 1'b1;
            end
            if (dev_en && reset_n) begin
                if (bus_read_request) rd_cnt = rd_wait + 1;
                if (bus_write_request) wr_cnt = wr_wait + 1;
            end
        end
    end

    // Monitor: bus pulses and manager responses are popped from the scoreboards.
    initial begin
        bus_t b;
        forever begin
            @(negedge clock);
            if (!m0_read_response) check("m0_data_quiet", m0_read_data, 32'h0);
            if (!m1_read_response) check("m1_data_quiet", m1_read_data, 32'h0);
`ifndef RVX_ARB_TIMEOUT_EN
            check("timeout_tied_low", 32'(bus_timeout), 32'h0);
`endif
            if (bus_read_request || bus_write_request) begin
                if (bus_q.size() == 0) begin
                    fail_now("unexpected_bus_pulse");
                end else begin
                    b = bus_q.pop_front();
                    check("bus_rw_address", bus_rw_address, b.addr);
                    check("bus_write_data", bus_write_data, b.wdata);
                    check("bus_write_strobe", 32'(bus_write_strobe), 32'(b.strb));
                    check("bus_read_request", 32'(bus_read_request), 32'(b.rd));
                    check("bus_write_request", 32'(bus_write_request), 32'(b.wr));
                end
            end
            if ((m0_read_response || m0_write_response) && (m1_read_response || m1_write_response))
                fail_now("both_managers_responded");
            if (m0_read_response || m0_write_response) handle_resp(1'b0);
            if (m1_read_response || m1_write_response) handle_resp(1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        vecs[0] = '{m: 0, rd: 1, wr: 0, addr: 32'h0000_1000, wd: 32'h0,         st: 4'h0, rw: 0, ww: 0, lat: 3};
        vecs[1] = '{m: 1, rd: 0, wr: 1, addr: 32'h0000_0040, wd: 32'hA5A5_A5A5, st: 4'h3, rw: 0, ww: 5, lat: 8};
        vecs[2] = '{m: 1, rd: 0, wr: 1, addr: 32'h0000_0044, wd: 32'h5A5A_5A5A, st: 4'hC, rw: 0, ww: 0, lat: 3};
        vecs[3] = '{m: 0, rd: 1, wr: 1, addr: 32'h0000_2000, wd: 32'h1234_5678, st: 4'hF, rw: 0, ww: 2, lat: 5};
        vecs[4] = '{m: 1, rd: 1, wr: 0, addr: 32'hFFFF_FFFC, wd: 32'h0,         st: 4'h0, rw: 2, ww: 0, lat: 5};
        vecs[5] = '{m: 0, rd: 0, wr: 1, addr: 32'h8000_0000, wd: 32'h0,         st: 4'hF, rw: 0, ww: 0, lat: 3};
        vecs[6] = '{m: 1, rd: 1, wr: 1, addr: 32'h0000_4004, wd: 32'hDEAD_BEEF, st: 4'hA, rw: 1, ww: 1, lat: 4};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clock);
        check("reset_bus_read_request", 32'(bus_read_request), 32'h0);
        check("reset_m0_read_response", 32'(m0_read_response), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            rd_wait = vecs[i].rw;
            wr_wait = vecs[i].ww;
            issue(vecs[i].m, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st,
                  vecs[i].lat, 1'b0);
            wait_idle();
        end

        // Reset while the bus is stalled: the transaction is dropped, the held request re-arbitrated.
        dev_en = 1'b0;
        rd_wait = 0;
        issue(1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h7777_0000, 4'h5, -1, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("rst_bus_rw_address", bus_rw_address, 32'h0);
        check("rst_bus_write_data", bus_write_data, 32'h0);
        check("rst_bus_write_strobe", 32'(bus_write_strobe), 32'h0);
        check("rst_bus_requests", 32'({bus_read_request, bus_write_request}), 32'h0);
        check("rst_m1_responses", 32'({m1_read_response, m1_write_response}), 32'h0);
        check("rst_bus_timeout", 32'(bus_timeout), 32'h0);
        resp_q.delete();
        reset_n = 1'b1;
        dev_en = 1'b1;
        expect_txn(1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h7777_0000, 4'h5, 3, 1'b0);
        wait_idle();

        // Simultaneous requests, m0 re-requesting at once: grants go m0, m1, m0.
        s = cyc;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 3, 1'b0);
        expect_txn(1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 7, 1'b0);
        while (cyc < s + 4) @(negedge clock);
        issue(1'b0, 1'b1, 1'b0, 32'h0000_5004, 32'h0, 4'h0, 7, 1'b0);
        wait_idle();

`ifdef RVX_ARB_TIMEOUT_EN
        dev_en = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 6, 1'b1);
        wait_idle();
        dev_en = 1'b1;
        // the response lands in the cycle the counter expires: real data, no timeout
        rd_wait = 3;
        issue(1'b0, 1'b1, 1'b0, 32'h0000_7004, 32'h0, 4'h0, 6, 1'b0);
        wait_idle();
`else
        rd_wait = 10;
        issue(1'b0, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 13, 1'b0);
        wait_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
